// File: rtl/mm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mm_seq_ctrl
//   Sequencer for a small NxN matrix-multiply engine placed between a UART
//   receiver and transmitter. Collects matrix A, then matrix B, as row-major
//   byte streams. Computes C = A*B with a single shared multiplier and
//   accumulator, one MAC per cycle. Streams C out as high byte then low byte
//   per element over a valid/ready handshake. When the last byte has been
//   accepted, it returns to loading A for the next pair.
//
//   N must be a power of two (>= 2): the element addresses are built by
//   concatenating row/column counters. Each result is sent as exactly two
//   bytes, so RW is 16.
//
// Ports
//   clk        clock (divided/baud domain)
//   rst        synchronous reset, active low
//   in_data    received byte
//   in_valid   one-cycle strobe qualifying in_data
//   out_data   result byte toward the transmitter
//   out_valid  out_data valid, held until accepted
//   out_ready  transmitter accepts when out_valid && out_ready at posedge
//   busy       high while computing or sending
//   state      encoded FSM state for debug LEDs
//   done       one-cycle pulse after the final result byte is transferred
//   drop       sticky flag: a byte arrived while not loading (reset clears)
// -----------------------------------------------------------------------------
module mm_seq_ctrl #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int RW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic [2:0]    state,
   output logic          done,
   output logic          drop
);

   localparam int E  = N * N;
   localparam int LW = $clog2(N);
   localparam int EW = $clog2(E);
   localparam int AW = 2 * DW + $clog2(N);
   localparam int NB = 2 * E;          // bytes streamed per result matrix
   localparam int BW = $clog2(NB);

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      COMPUTE = 3'd2,
      SEND    = 3'd3
   } state_t;

   state_t state_reg, state_next;

   logic [DW-1:0] a_mem [E];
   logic [DW-1:0] b_mem [E];
   logic [RW-1:0] c_mem [E];

   logic [EW-1:0] load_idx_reg;
   logic [LW-1:0] mac_i_reg, mac_j_reg, mac_k_reg;
   logic [AW-1:0] acc_reg;
   logic [BW-1:0] send_idx_reg;
   logic [7:0]    out_data_reg;
   logic          out_valid_reg;
   logic          done_reg;
   logic          drop_reg;

   // ---------------------------------------------------------------- datapath
   logic          load_last;
   logic          k_last, j_last, i_last, mac_last;
   logic          xfer, send_last;
   logic [2*DW-1:0] product;
   logic [AW-1:0] acc_sum;
   logic [BW-1:0] sel_idx;
   logic [RW-1:0] sel_word;
   logic [7:0]    sel_byte;

   assign load_last = in_valid && (load_idx_reg == EW'(E - 1));
   assign k_last    = (mac_k_reg == LW'(N - 1));
   assign j_last    = (mac_j_reg == LW'(N - 1));
   assign i_last    = (mac_i_reg == LW'(N - 1));
   assign mac_last  = k_last && j_last && i_last;
   assign xfer      = out_valid_reg && out_ready;
   assign send_last = xfer && (send_idx_reg == BW'(NB - 1));

   assign product = (2*DW)'(a_mem[{mac_i_reg, mac_k_reg}]) *
                    (2*DW)'(b_mem[{mac_k_reg, mac_j_reg}]);
   assign acc_sum = acc_reg + AW'(product);

   // Byte to present next: the current index on the first SEND cycle (nothing
   // shown yet), otherwise the one after the byte being transferred now.
   assign sel_idx  = out_valid_reg ? send_idx_reg + 1'b1 : send_idx_reg;
   assign sel_word = c_mem[sel_idx[BW-1:1]];
   assign sel_byte = sel_idx[0] ? sel_word[7:0] : sel_word[15:8];

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) state_reg <= LOAD_A;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LOAD_A:  if (load_last) state_next = LOAD_B;
         LOAD_B:  if (load_last) state_next = COMPUTE;
         COMPUTE: if (mac_last)  state_next = SEND;
         SEND:    if (send_last) state_next = LOAD_A;
         default:                state_next = LOAD_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         load_idx_reg  <= '0;
         mac_i_reg     <= '0;
         mac_j_reg     <= '0;
         mac_k_reg     <= '0;
         acc_reg       <= '0;
         send_idx_reg  <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
         drop_reg      <= 1'b0;
         for (int e = 0; e < E; e++) begin
            a_mem[e] <= '0;
            b_mem[e] <= '0;
            c_mem[e] <= '0;
         end
      end else begin
         done_reg <= 1'b0;
         // A byte arriving on the final SEND edge is also discarded here.
         if (in_valid && (state_reg == COMPUTE || state_reg == SEND))
            drop_reg <= 1'b1;

         case (state_reg)
            LOAD_A: begin
               if (in_valid) begin
                  a_mem[load_idx_reg] <= in_data;
                  load_idx_reg <= load_last ? '0 : load_idx_reg + 1'b1;
               end
            end
            LOAD_B: begin
               if (in_valid) begin
                  b_mem[load_idx_reg] <= in_data;
                  load_idx_reg <= load_last ? '0 : load_idx_reg + 1'b1;
                  if (load_last) begin
                     mac_i_reg <= '0;
                     mac_j_reg <= '0;
                     mac_k_reg <= '0;
                     acc_reg   <= '0;
                  end
               end
            end
            COMPUTE: begin
               if (k_last) begin
                  // Fold the last product in directly so each element costs N cycles.
                  c_mem[{mac_i_reg, mac_j_reg}] <= RW'(acc_sum);
                  acc_reg   <= '0;
                  mac_k_reg <= '0;
                  if (j_last) begin
                     mac_j_reg <= '0;
                     mac_i_reg <= i_last ? '0 : mac_i_reg + 1'b1;
                  end else begin
                     mac_j_reg <= mac_j_reg + 1'b1;
                  end
               end else begin
                  acc_reg   <= acc_sum;
                  mac_k_reg <= mac_k_reg + 1'b1;
               end
            end
            SEND: begin
               if (!out_valid_reg) begin
                  out_data_reg  <= sel_byte;
                  out_valid_reg <= 1'b1;
               end else if (out_ready) begin
                  if (send_last) begin
                     out_valid_reg <= 1'b0;
                     done_reg      <= 1'b1;
                     send_idx_reg  <= '0;
                  end else begin
                     out_data_reg <= sel_byte;
                     send_idx_reg <= send_idx_reg + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign busy      = (state_reg == COMPUTE) || (state_reg == SEND);
   assign state     = state_reg;
   assign done      = done_reg;
   assign drop      = drop_reg;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mm_seq_ctrl
//   Self-checking bench for mm_seq_ctrl. A reference model computes C = A*B
//   with plain integer loops and queues the expected 32-byte stream. Inputs
//   use randomized gaps and randomized out_ready back-pressure. The bench
//   prints one line per matrix pair.
// -----------------------------------------------------------------------------
module tb_mm_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic [2:0] state;
   logic       done;
   logic       drop;

   mm_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .state     (state),
      .done      (done),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] ma [16];
   logic [7:0] mb [16];
   logic [7:0] exp_q [$];
   bit         drop_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j] mod 65536, sent hi then lo.
   task automatic build_model();
      int c;
      exp_q.delete();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            c = 0;
            for (int k = 0; k < 4; k++)
               c += int'(ma[i*4+k]) * int'(mb[k*4+j]);
            c = c % 65536;
            exp_q.push_back(8'((c >> 8) & 255));
            exp_q.push_back(8'(c & 255));
         end
   endtask

   task automatic load_matrix(input bit is_b);
      for (int e = 0; e < 16; e++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         in_valid = 1'b1;
         in_data  = is_b ? mb[e] : ma[e];
         tick();
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic set_identity_ramp();
      for (int e = 0; e < 16; e++) begin
         ma[e] = (e / 4 == e % 4) ? 8'd1 : 8'd0;
         mb[e] = 8'(e + 1);
      end
   endtask

   task automatic set_random();
      for (int e = 0; e < 16; e++) begin
         ma[e] = 8'($urandom_range(0, 255));
         mb[e] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic run_pair(input string name, input bit stall, input bit poke_compute,
                           input bit poke_final);
      int cycles, bad_busy, bad_state, n, guard, stall_cnt;
      int bad_valid, bad_hold, bad_done, bad_busy2;
      bit rdy, prev_stalled;
      logic [7:0] prev_data;

      build_model();
      load_matrix(1'b0);
      load_matrix(1'b1);

      // Now just past the edge that sampled the last B byte.
      cycles = 0; bad_busy = 0; bad_state = 0;
      while (out_valid !== 1'b1 && cycles < 200) begin
         if (poke_compute && cycles == 10) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            drop_exp = 1'b1;
         end
         tick();
         in_valid = 1'b0;
         cycles++;
         if (out_valid !== 1'b1) begin
            if (busy !== 1'b1) bad_busy++;
            if (state !== ((cycles < 64) ? 3'd2 : 3'd3)) bad_state++;
         end
      end
      check({name, " latency"}, cycles, 65);
      check({name, " busy_compute"}, bad_busy, 0);
      check({name, " state_compute"}, bad_state, 0);

      n = 0; guard = 0; stall_cnt = 0; prev_stalled = 1'b0; prev_data = 8'h00;
      bad_valid = 0; bad_hold = 0; bad_done = 0; bad_busy2 = 0;
      while (n < 32 && guard < 3000) begin
         if (out_valid !== 1'b1) bad_valid++;
         if (busy !== 1'b1) bad_busy2++;
         if (done !== 1'b0) bad_done++;
         if (prev_stalled && out_data !== prev_data) bad_hold++;
         if (stall && n == 8 && stall_cnt < 10) begin
            rdy = 1'b0;
            stall_cnt++;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         out_ready = rdy;
         if (rdy) begin
            check($sformatf("%s byte%0d", name, n), out_data, exp_q[n]);
            n++;
            if (n == 32 && poke_final) begin
               in_valid = 1'b1;
               in_data  = 8'($urandom);
               drop_exp = 1'b1;
            end
         end
         prev_stalled = !rdy;
         prev_data    = out_data;
         tick();
         in_valid = 1'b0;
         guard++;
      end
      out_ready = 1'($urandom_range(0, 1));
      check({name, " byte_count"}, n, 32);
      check({name, " valid_held"}, bad_valid, 0);
      check({name, " data_frozen"}, bad_hold, 0);
      check({name, " busy_send"}, bad_busy2, 0);
      check({name, " done_early"}, bad_done, 0);
      check({name, " valid_end"}, out_valid, 0);
      check({name, " done_pulse"}, done, 1);
      check({name, " state_end"}, state, 0);
      check({name, " busy_end"}, busy, 0);
      check({name, " drop"}, drop, drop_exp);
      tick();
      check({name, " done_clear"}, done, 0);
      out_ready = 1'b0;
      $display("pair %s latency=%0d send_cycles=%0d drop=%0b", name, cycles, guard, drop);
   endtask

   task automatic check_reset_state(input string name);
      check({name, " state"}, state, 0);
      check({name, " out_valid"}, out_valid, 0);
      check({name, " out_data"}, out_data, 0);
      check({name, " busy"}, busy, 0);
      check({name, " done"}, done, 0);
      check({name, " drop"}, drop, 0);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; drop_exp = 1'b0;
      repeat (3) tick();
      check_reset_state("reset");
      rst = 1'b1;
      tick();

      set_identity_ramp();
      run_pair("identity", 1'b0, 1'b0, 1'b0);

      for (int e = 0; e < 16; e++) begin
         ma[e] = 8'hFF;
         mb[e] = 8'hFF;
      end
      run_pair("all_ff", 1'b0, 1'b0, 1'b0);

      set_identity_ramp();
      run_pair("stall", 1'b1, 1'b0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         set_random();
         run_pair($sformatf("random%0d", r), 1'b0, 1'b0, 1'b0);
      end

      set_identity_ramp();
      run_pair("drop_compute", 1'b0, 1'b1, 1'b0);

      set_random();
      run_pair("drop_final", 1'b0, 1'b0, 1'b1);

      set_random();
      run_pair("after_final", 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a compute, then reload.
      set_random();
      load_matrix(1'b0);
      load_matrix(1'b1);
      repeat (30) tick();
      check("mid_compute state", state, 2);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      drop_exp = 1'b0;
      check_reset_state("mid_reset");
      tick();

      set_identity_ramp();
      run_pair("reload", 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
